// File: rtl/fifo_pkg.sv
// Purpose: shared types and helpers for the async FIFO family and its read-side adapters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default word width, default prefetch depth, occupancy type, gray/binary helpers.
package fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_BUF_DEPTH = 3;

    // Occupancy count for the default prefetch depth (0..DEF_BUF_DEPTH).
    typedef logic [$clog2(DEF_BUF_DEPTH+1)-1:0] occ_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_prefetch_buf.sv
// Purpose: BUF_DEPTH-entry circular register buffer holding prefetched FIFO words.
// Latency: push visible at head_data/occ one edge later; head_data is a plain register read.
// Backpressure: none internally; the caller never pushes when full nor pops when empty.
// Ports: clk/rst_n, push+push_data (write at tail), pop (advance head), clear (drop all),
//        head_data (oldest entry), occ (entries held).
module fifo_rd_prefetch_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    localparam int OCC_W    = $clog2(BUF_DEPTH+1),
    localparam int PTR_W    = $clog2(BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_data = mem[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            // Clear wins over a same-edge push or pop: everything buffered is dropped.
            head <= tail;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Purpose: turns the async FIFO read port (r_en + registered data_out) into a valid/ready stream.
// Latency: 2 edges from fifo_r_en to m_valid (issue, capture); one word per cycle sustained.
// Backpressure: m_ready low fills the prefetch buffer, then fifo_r_en stops; no m_ready->r_en path.
// Ports: r_clk/r_rst_n, flush, fifo_empty/fifo_data_out/fifo_r_en (FIFO side),
//        m_valid/m_ready/m_data (stream side), occupancy (buffered words), rd_count (words delivered).
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int CNT_WIDTH = 16,
    localparam int OCC_W    = $clog2(BUF_DEPTH+1)
) (
    input  logic                 r_clk,
    input  logic                 r_rst_n,
    input  logic                 flush,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data_out,
    output logic                 fifo_r_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic [OCC_W-1:0]     occupancy,
    output logic [CNT_WIDTH-1:0] rd_count
);

    logic             inflight;
    logic             discard;
    logic             push;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   committed;

    // Buffered plus in-flight words; issuing only while this is below depth
    // guarantees every word read from the FIFO has a slot waiting for it.
    assign committed = {1'b0, occ} + (OCC_W+1)'(inflight);

    assign fifo_r_en = r_rst_n && !fifo_empty && !flush
                       && (committed < (OCC_W+1)'(BUF_DEPTH));

    assign m_valid   = (occ != '0);
    assign pop       = m_valid && m_ready;
    // A word arriving in a flush cycle, or already marked for discard, is dropped.
    assign push      = inflight && !discard && !flush;
    assign occupancy = occ;

    fifo_rd_prefetch_buf #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (r_clk),
        .rst_n     (r_rst_n),
        .push      (push),
        .push_data (fifo_data_out),
        .pop       (pop),
        .clear     (flush),
        .head_data (m_data),
        .occ       (occ)
    );

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            inflight <= 1'b0;
            discard  <= 1'b0;
            rd_count <= '0;
        end else begin
            inflight <= fifo_r_en;
            discard  <= flush && inflight;
            // A handshake in a flush cycle still counts as delivered.
            if (pop) begin
                rd_count <= rd_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
module tb_fifo_rd_stream_adapter;
    import fifo_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CW    = 16;

    logic             r_clk = 1'b0;
    logic             r_rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_data_out = '0;
    logic             fifo_r_en;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    occ_t             occupancy;
    logic [CW-1:0]    rd_count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] fifo_q [$];
    logic [WIDTH-1:0] got [$];
    logic             fre_s = 1'b0;
    int               pulses = 0;

    fifo_rd_stream_adapter #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .r_clk         (r_clk),
        .r_rst_n       (r_rst_n),
        .flush         (flush),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_r_en     (fifo_r_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .occupancy     (occupancy),
        .rd_count      (rd_count)
    );

    always #5 r_clk = ~r_clk;

    // FIFO read-port model: registered data_out updates on the edge that accepts r_en.
    always begin
        @(posedge r_clk);
        #1;
        if (fre_s && fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    end

    // Mid-cycle monitor: inputs change only just after posedge, so these are the values the next edge sees.
    always @(negedge r_clk) begin
        fre_s = fifo_r_en;
        if (fifo_r_en) pulses++;
        if (m_valid && m_ready) got.push_back(m_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic preload(input logic [WIDTH-1:0] first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(first + WIDTH'(i));
        fifo_empty = 1'b0;
    endtask

    task automatic test_reset();
        r_rst_n = 1'b0;
        repeat (2) tick();
        r_rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge r_clk);
            checks++;
            if (fifo_r_en !== 1'b0 || m_valid !== 1'b0 || occupancy !== '0 || rd_count !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: r_en=%b valid=%b occ=%0d cnt=%0d, required 0 0 0 0",
                         c, fifo_r_en, m_valid, occupancy, rd_count);
            end
        end
    endtask

    task automatic test_stream();
        tick();
        m_ready = 1'b1;
        preload(8'h01, 8);
        @(negedge r_clk);
        checks++;
        if (fifo_r_en !== 1'b1) begin
            errors++;
            $display("FAIL stream_issue: r_en=%b, required 1", fifo_r_en);
        end
        @(negedge r_clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_latency: valid=%b after 1 edge, required 0", m_valid);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge r_clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== WIDTH'(i + 1)) begin
                errors++;
                $display("FAIL stream_word %0d: valid=%b data=%h, required 1 %h", i, m_valid, m_data, i + 1);
            end
        end
        @(negedge r_clk);
        checks++;
        if (m_valid !== 1'b0 || rd_count !== CW'(8)) begin
            errors++;
            $display("FAIL stream_end: valid=%b cnt=%0d, required 0 8", m_valid, rd_count);
        end
    endtask

    task automatic test_backpressure();
        tick();
        m_ready = 1'b0;
        pulses = 0;
        preload(8'h01, 8);
        for (int c = 0; c < 10; c++) begin
            @(negedge r_clk);
            if (m_valid) begin
                checks++;
                if (m_data !== 8'h01) begin
                    errors++;
                    $display("FAIL bp_hold cyc %0d: data=%h, required 01", c, m_data);
                end
            end
        end
        checks++;
        if (pulses != 3 || occupancy !== occ_t'(3) || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_fill: pulses=%0d occ=%0d valid=%b, required 3 3 1", pulses, occupancy, m_valid);
        end
        tick();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge r_clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== WIDTH'(i + 1)) begin
                errors++;
                $display("FAIL bp_drain %0d: valid=%b data=%h, required 1 %h", i, m_valid, m_data, i + 1);
            end
        end
        @(negedge r_clk);
        checks++;
        if (rd_count !== CW'(16)) begin
            errors++;
            $display("FAIL bp_count: cnt=%0d, required 16", rd_count);
        end
    endtask

    task automatic test_toggle();
        tick();
        got.delete();
        preload(8'hA0, 16);
        for (int c = 0; c < 60; c++) begin
            m_ready = ((c % 2) == 0);
            tick();
        end
        m_ready = 1'b0;
        checks++;
        if (got.size() != 16) begin
            errors++;
            $display("FAIL toggle_size: got %0d words, required 16", got.size());
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 8'hA0 + WIDTH'(i)) begin
                errors++;
                $display("FAIL toggle_word %0d: data=%h, required %h", i, got[i], 8'hA0 + i);
            end
        end
        checks++;
        if (rd_count !== CW'(32)) begin
            errors++;
            $display("FAIL toggle_count: cnt=%0d, required 32", rd_count);
        end
    endtask

    task automatic test_flush();
        tick();
        got.delete();
        m_ready = 1'b0;
        preload(8'h11, 6);
        // Issues at 3 edges: after the third, two words buffered and one in flight.
        repeat (3) tick();
        checks++;
        if (occupancy !== occ_t'(2)) begin
            errors++;
            $display("FAIL flush_setup: occ=%0d, required 2", occupancy);
        end
        flush = 1'b1;
        @(negedge r_clk);
        checks++;
        if (fifo_r_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_ren: r_en=%b, required 0", fifo_r_en);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (occupancy !== '0 || m_valid !== 1'b0 || rd_count !== CW'(32)) begin
            errors++;
            $display("FAIL flush_clear: occ=%0d valid=%b cnt=%0d, required 0 0 32", occupancy, m_valid, rd_count);
        end
        m_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (got.size() != 3 || got[0] !== 8'h14 || got[1] !== 8'h15 || got[2] !== 8'h16) begin
            errors++;
            $display("FAIL flush_resume: %0d words first=%h, required 3 words 14 15 16",
                     got.size(), (got.size() > 0) ? got[0] : 8'h00);
        end
        checks++;
        if (rd_count !== CW'(35)) begin
            errors++;
            $display("FAIL flush_count: cnt=%0d, required 35", rd_count);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        m_ready = 1'b0;
        preload(8'h21, 4);
        repeat (3) tick();
        checks++;
        if (occupancy !== occ_t'(2)) begin
            errors++;
            $display("FAIL rstmid_setup: occ=%0d, required 2", occupancy);
        end
        r_rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || fifo_r_en !== 1'b0 || occupancy !== '0) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b r_en=%b occ=%0d, required 0 0 0", m_valid, fifo_r_en, occupancy);
        end
        fifo_q.delete();
        fifo_empty = 1'b1;
        fifo_data_out = '0;
        repeat (2) tick();
        r_rst_n = 1'b1;
        @(negedge r_clk);
        checks++;
        if (fifo_r_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || occupancy !== '0 || rd_count !== '0) begin
            errors++;
            $display("FAIL rstmid_after: r_en=%b valid=%b data=%h occ=%0d cnt=%0d, required all 0",
                     fifo_r_en, m_valid, m_data, occupancy, rd_count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
- Sits on the read side of the asynchronous FIFO, in the r_clk domain.
- Drives the FIFO's r_en and absorbs its one-cycle registered read latency (data_out updates on the edge that accepts r_en).
- Presents the FIFO contents as a valid/ready stream to downstream logic.
- Uses a small prefetch buffer to sustain one word per cycle, with no combinational path from m_ready to fifo_r_en.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- BUF_DEPTH, 3, prefetch buffer entries; minimum 3, which is required for full throughput.
- CNT_WIDTH, 16, width of the drained-word counter.

Ports:
- r_clk  in  1  read-domain clock; all logic is on its rising edge.
- r_rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of buffered and in-flight words.
- fifo_empty  in  1  FIFO empty flag (r_clk domain).
- fifo_data_out  in  WIDTH  FIFO registered read data.
- fifo_r_en  out  1  FIFO read enable.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream accept.
- m_data  out  WIDTH  stream data; equals the buffer head entry.
- occupancy  out  $clog2(BUF_DEPTH+1)  buffered word count.
- rd_count  out  CNT_WIDTH  words delivered downstream; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (r_rst_n low, asynchronous):
  - occ=0, inflight=0, discard=0, buffer pointers=0, rd_count=0.
  - m_valid=0, m_data=0, fifo_r_en=0. fifo_r_en is gated low combinationally while reset is asserted.
- Issue rule (combinational from registers and inputs only):
  - fifo_r_en = !fifo_empty && !flush && (occ + inflight < BUF_DEPTH).
  - fifo_r_en never depends on m_ready.
- inflight is registered and set to 1 on an edge where fifo_r_en=1; otherwise cleared.
  - At most one word is in flight.
- Capture: on an edge with inflight=1 and discard=0, fifo_data_out is written at the buffer tail.
  - Latency from the fifo_r_en edge to m_valid is 2 edges: issue at edge k, capture at edge k+1, m_valid high after k+1.
- Pop: when m_valid && m_ready at an edge, the head advances and rd_count increments.
  - Capture and pop on the same edge leave occ unchanged.
- m_valid = (occ != 0). m_data and m_valid must hold stable while m_valid && !m_ready.
- Pointer wrap: head and tail wrap modulo BUF_DEPTH; non-power-of-2 depths must work.
- Throughput:
  - With the FIFO non-empty and m_ready held high, steady state is occ=1, inflight=1, one word per cycle.
  - First m_valid appears 2 cycles after fifo_empty falls.
- Backpressure: with m_ready low, the block issues until occ+inflight=BUF_DEPTH, then holds fifo_r_en=0. No word is ever lost or duplicated.
- fifo_empty is sampled only at issue. The FIFO ignores r_en when empty; the gating above guarantees the block never counts a read the FIFO refused.
- Flush (held for one or more cycles):
  - fifo_r_en=0 during flush.
  - A handshake in the flush cycle completes normally and is counted.
  - At the edge: occ=0 and head=tail. If inflight=1, discard is set so that word is dropped at the next edge; discard then clears.
  - rd_count is not cleared.
- Simultaneous flush and capture: the capture is dropped.
- Reset mid-transfer: all state is lost immediately; m_valid falls asynchronously. The FIFO's own reset is the owner's responsibility.

Decomposition:
- Shared package fifo_pkg:
  - function gray2bin/bin2gray (reused by FIFO variants).
  - localparam default WIDTH.
  - typedef of the occupancy count type.
- Sub-module fifo_rd_prefetch_buf:
  - BUF_DEPTH circular register buffer with head/tail/occ.
  - Ports: push, push_data, pop, clear, head_data, occ.
- The top holds the issue/inflight/discard logic and rd_count.

Test Plan:
- Reset then fifo_empty=1 for 10 cycles -> fifo_r_en=0, m_valid=0, occupancy=0, rd_count=0 throughout.
- FIFO preloaded with 0x01..0x08, m_ready=1 -> fifo_r_en rises the same cycle fifo_empty falls; m_valid 2 edges later; 0x01..0x08 delivered on 8 consecutive cycles; rd_count=8.
- Same preload, m_ready=0 for 10 cycles -> exactly 3 fifo_r_en pulses, occupancy=3, m_data=0x01 stable. m_ready then goes to 1 -> remaining words delivered in order, no gaps after the first.
- m_ready toggled with a 1010 pattern over 16 words 0xA0..0xAF -> in-order delivery, no loss or duplication, rd_count=16.
- occupancy=2 and inflight=1, then flush for 1 cycle -> next edge occupancy=0; in-flight word not delivered; next words resume in FIFO order; rd_count unchanged by flush.
- r_rst_n pulled low mid-stream with occupancy=2 -> m_valid and fifo_r_en fall immediately; after release all outputs read 0.
